// File: rtl/dffram_arbiter.sv
// Two-master arbiter for a single-port DFFRAM macro: grants one request per cycle,
// registers it onto the macro pins and steers read data back via a tag pipeline.
module dffram_arbiter #(
   parameter int WSIZE      = 4,
   parameter int AWIDTH     = 7,
   parameter int RD_LAT     = 1,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 REQ0,
   input  logic [WSIZE-1:0]     WE0_P0,
   input  logic [AWIDTH-1:0]    A_P0,
   input  logic [WSIZE*8-1:0]   DI_P0,
   output logic                 GNT0,
   output logic                 RVALID0,
   output logic [WSIZE*8-1:0]   DO_P0,
   input  logic                 REQ1,
   input  logic [WSIZE-1:0]     WE0_P1,
   input  logic [AWIDTH-1:0]    A_P1,
   input  logic [WSIZE*8-1:0]   DI_P1,
   output logic                 GNT1,
   output logic                 RVALID1,
   output logic [WSIZE*8-1:0]   DO_P1,
   output logic                 MEM_EN0,
   output logic [WSIZE-1:0]     MEM_WE0,
   output logic [AWIDTH-1:0]    MEM_A0,
   output logic [WSIZE*8-1:0]   MEM_Di0,
   input  logic [WSIZE*8-1:0]   MEM_Do0,
   output logic                 BUSY
);

   localparam int NTAG = 1 + RD_LAT;

   typedef struct packed {
      logic valid;
      logic port;
   } tag_t;

   logic                 last;
   logic                 gnt0;
   logic                 gnt1;
   logic                 xfer;
   logic                 win;
   logic [WSIZE-1:0]     sel_we;
   logic [AWIDTH-1:0]    sel_a;
   logic [WSIZE*8-1:0]   sel_di;
   tag_t                 new_tag;
   tag_t [NTAG-1:0]      tag_q;
   logic                 inflight;

   // On contention the port that did not win last time goes first; reset leaves
   // last at 1 so port 0 takes the first contended slot.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (RST_N) begin
         if (REQ0 && REQ1) begin
            if (FIXED_PRIO || last) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
         end else begin
            gnt0 = REQ0;
            gnt1 = REQ1;
         end
      end
   end

   assign GNT0 = gnt0;
   assign GNT1 = gnt1;
   assign xfer = gnt0 | gnt1;
   assign win  = gnt1;

   always_comb begin
      sel_we = win ? WE0_P1 : WE0_P0;
      sel_a  = win ? A_P1   : A_P0;
      sel_di = win ? DI_P1  : DI_P0;
      new_tag.valid = xfer && (sel_we == '0);
      new_tag.port  = win;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         last    <= 1'b1;
         MEM_EN0 <= 1'b0;
         MEM_WE0 <= '0;
         MEM_A0  <= '0;
         MEM_Di0 <= '0;
         tag_q   <= '0;
      end else begin
         MEM_EN0 <= xfer;
         MEM_WE0 <= '0;
         if (xfer) begin
            last    <= win;
            MEM_WE0 <= sel_we;
            MEM_A0  <= sel_a;
            MEM_Di0 <= sel_di;
         end
         // tag_q[0] is the newest entry; the oldest lines up with macro read data
         tag_q <= {tag_q[NTAG-2:0], new_tag};
      end
   end

   always_comb begin
      inflight = 1'b0;
      for (int i = 0; i < NTAG; i++) begin
         inflight = inflight | tag_q[i].valid;
      end
   end

   assign RVALID0 = tag_q[NTAG-1].valid && !tag_q[NTAG-1].port;
   assign RVALID1 = tag_q[NTAG-1].valid &&  tag_q[NTAG-1].port;
   assign DO_P0   = MEM_Do0;
   assign DO_P1   = MEM_Do0;
   assign BUSY    = inflight | MEM_EN0;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Bench for dffram_arbiter: directed scenarios plus random traffic, checked against
// a transaction-level model (grant rule, reference memory, response schedule).
module tb_dffram_arbiter;

   localparam int WSIZE  = 4;
   localparam int AWIDTH = 7;
   localparam int RD_LAT = 1;
   localparam int NSLOT  = 8;

   typedef struct {
      logic [3:0]  we;
      logic [6:0]  a;
      logic [31:0] d;
   } op_t;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        REQ0 = 1'b0, REQ1 = 1'b0;
   logic [3:0]  WE0_P0 = '0, WE0_P1 = '0;
   logic [6:0]  A_P0 = '0, A_P1 = '0;
   logic [31:0] DI_P0 = '0, DI_P1 = '0;
   logic        GNT0, GNT1, RVALID0, RVALID1, BUSY;
   logic [31:0] DO_P0, DO_P1;
   logic        MEM_EN0;
   logic [3:0]  MEM_WE0;
   logic [6:0]  MEM_A0;
   logic [31:0] MEM_Di0;
   logic [31:0] MEM_Do0 = '0;

   logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_busy, fp_en;
   logic [3:0]  fp_we;
   logic [6:0]  fp_a;
   logic [31:0] fp_di, fp_do0, fp_do1;
   logic [31:0] fp_rdata = '0;

   logic [31:0] macro_mem [128] = '{default: '0};
   logic [31:0] ref_mem   [128] = '{default: '0};

   op_t         q0[$];
   op_t         q1[$];
   logic        rsp_v [NSLOT] = '{default: 1'b0};
   logic        rsp_p [NSLOT] = '{default: 1'b0};
   logic [31:0] rsp_d [NSLOT] = '{default: '0};
   int          cyc = 0;
   logic        last_m = 1'b1, en_m = 1'b0, fp_en_m = 1'b0;
   logic [6:0]  a_m = '0, fp_a_m = '0;
   logic [3:0]  we_m = '0;
   logic        g0, g1;
   int          n_tests = 0, n_fail = 0;

   dffram_arbiter #(.WSIZE(WSIZE), .AWIDTH(AWIDTH), .RD_LAT(RD_LAT), .FIXED_PRIO(1'b0)) u_dut (
      .CLK(CLK), .RST_N(RST_N),
      .REQ0(REQ0), .WE0_P0(WE0_P0), .A_P0(A_P0), .DI_P0(DI_P0),
      .GNT0(GNT0), .RVALID0(RVALID0), .DO_P0(DO_P0),
      .REQ1(REQ1), .WE0_P1(WE0_P1), .A_P1(A_P1), .DI_P1(DI_P1),
      .GNT1(GNT1), .RVALID1(RVALID1), .DO_P1(DO_P1),
      .MEM_EN0(MEM_EN0), .MEM_WE0(MEM_WE0), .MEM_A0(MEM_A0), .MEM_Di0(MEM_Di0),
      .MEM_Do0(MEM_Do0), .BUSY(BUSY)
   );

   dffram_arbiter #(.WSIZE(WSIZE), .AWIDTH(AWIDTH), .RD_LAT(RD_LAT), .FIXED_PRIO(1'b1)) u_fp (
      .CLK(CLK), .RST_N(RST_N),
      .REQ0(REQ0), .WE0_P0(WE0_P0), .A_P0(A_P0), .DI_P0(DI_P0),
      .GNT0(fp_gnt0), .RVALID0(fp_rvalid0), .DO_P0(fp_do0),
      .REQ1(REQ1), .WE0_P1(WE0_P1), .A_P1(A_P1), .DI_P1(DI_P1),
      .GNT1(fp_gnt1), .RVALID1(fp_rvalid1), .DO_P1(fp_do1),
      .MEM_EN0(fp_en), .MEM_WE0(fp_we), .MEM_A0(fp_a), .MEM_Di0(fp_di),
      .MEM_Do0(fp_rdata), .BUSY(fp_busy)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] m);
      merge = old;
      for (int b = 0; b < 4; b++) begin
         if (m[b]) merge[b*8 +: 8] = nw[b*8 +: 8];
      end
   endfunction

   // macro stand-in: one-cycle synchronous read, byte-masked write
   always @(posedge CLK) begin
      if (MEM_EN0) begin
         if (MEM_WE0 == 4'h0) MEM_Do0 <= macro_mem[MEM_A0];
         else macro_mem[MEM_A0] <= merge(macro_mem[MEM_A0], MEM_Di0, MEM_WE0);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic op_t wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
      op_t o;
      o.we = m; o.a = a; o.d = d;
      return o;
   endfunction

   function automatic op_t rd(input logic [6:0] a);
      op_t o;
      o.we = 4'h0; o.a = a; o.d = $urandom;
      return o;
   endfunction

   function automatic logic pending();
      pending = 1'b0;
      for (int i = 0; i < NSLOT; i++) pending = pending | rsp_v[i];
   endfunction

   task automatic drive();
      REQ0 = (q0.size() > 0);
      REQ1 = (q1.size() > 0);
      if (REQ0) begin WE0_P0 = q0[0].we; A_P0 = q0[0].a; DI_P0 = q0[0].d; end
      if (REQ1) begin WE0_P1 = q1[0].we; A_P1 = q1[0].a; DI_P1 = q1[0].d; end
   endtask

   task automatic check_cycle();
      int s;
      g0 = 1'b0;
      g1 = 1'b0;
      if (RST_N) begin
         if (REQ0 && REQ1) begin
            if (last_m) g0 = 1'b1; else g1 = 1'b1;
         end else begin
            g0 = REQ0;
            g1 = REQ1;
         end
      end
      check("gnt0", 32'(GNT0), 32'(g0));
      check("gnt1", 32'(GNT1), 32'(g1));
      check("fp_gnt0", 32'(fp_gnt0), 32'(RST_N & REQ0));
      check("fp_gnt1", 32'(fp_gnt1), 32'(RST_N & REQ1 & ~REQ0));
      s = cyc % NSLOT;
      check("rvalid0", 32'(RVALID0), 32'(rsp_v[s] && !rsp_p[s]));
      check("rvalid1", 32'(RVALID1), 32'(rsp_v[s] && rsp_p[s]));
      if (rsp_v[s]) begin
         if (rsp_p[s]) check("do_p1", DO_P1, rsp_d[s]);
         else check("do_p0", DO_P0, rsp_d[s]);
      end
      check("busy", 32'(BUSY), 32'(en_m | pending()));
      check("mem_en", 32'(MEM_EN0), 32'(en_m));
      check("mem_we", 32'(MEM_WE0), en_m ? 32'(we_m) : 32'd0);
      if (en_m) check("mem_a", 32'(MEM_A0), 32'(a_m));
      check("fp_en", 32'(fp_en), 32'(fp_en_m));
      if (fp_en_m) check("fp_a", 32'(fp_a), 32'(fp_a_m));
   endtask

   task automatic model_edge();
      op_t  op;
      logic p;
      int   s;
      rsp_v[cyc % NSLOT] = 1'b0;
      if (!RST_N) begin
         for (int i = 0; i < NSLOT; i++) rsp_v[i] = 1'b0;
         en_m = 1'b0;
         fp_en_m = 1'b0;
         last_m = 1'b1;
      end else begin
         fp_en_m = REQ0 | REQ1;
         fp_a_m  = REQ0 ? A_P0 : A_P1;
         en_m    = g0 | g1;
         if (g0 | g1) begin
            p = g1;
            if (p) op = q1.pop_front(); else op = q0.pop_front();
            last_m = p;
            a_m = op.a;
            we_m = op.we;
            if (op.we == 4'h0) begin
               s = (cyc + 1 + RD_LAT) % NSLOT;
               rsp_v[s] = 1'b1;
               rsp_p[s] = p;
               rsp_d[s] = ref_mem[op.a];
            end else begin
               ref_mem[op.a] = merge(ref_mem[op.a], op.d, op.we);
            end
         end
      end
      cyc++;
   endtask

   task automatic step();
      drive();
      @(negedge CLK);
      check_cycle();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || en_m || pending()) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got timeout after %0d cycles expected idle", n);
      end
      step();
   endtask

   function automatic op_t rand_op();
      op_t o;
      o.a  = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
      o.we = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      o.d  = $urandom;
      return o;
   endfunction

   initial begin
      #60000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      // request pending while in reset must not be granted
      q0.push_back(wr(7'h00, 32'hAA0055BB, 4'hF));
      step();
      step();
      RST_N = 1'b1;
      q0.push_back(rd(7'h00));
      drain();

      q0.push_back(wr(7'h01, 32'hAA0055CC, 4'hF));
      q0.push_back(wr(7'h01, 32'h00003300, 4'h2));
      q0.push_back(rd(7'h01));
      q0.push_back(wr(7'h02, 32'hAA0055DD, 4'hF));
      q0.push_back(wr(7'h02, 32'h00000033, 4'h1));
      q0.push_back(rd(7'h02));
      q0.push_back(wr(7'h10, 32'h11111111, 4'hF));
      q1.push_back(wr(7'h70, 32'hF0F055BB, 4'hF));
      q1.push_back(wr(7'h71, 32'hF0F055CC, 4'hF));
      q1.push_back(wr(7'h72, 32'hF0F055DD, 4'hF));
      drain();
      check("ref_0x01", ref_mem[7'h01], 32'hAA0033CC);
      check("ref_0x02", ref_mem[7'h02], 32'hAA005533);

      // contention straight after reset: port 0 first, then alternate
      RST_N = 1'b0;
      step();
      RST_N = 1'b1;
      q0.push_back(rd(7'h10));
      q0.push_back(rd(7'h10));
      q1.push_back(rd(7'h70));
      q1.push_back(rd(7'h70));
      drain();

      q1.push_back(rd(7'h70));
      q1.push_back(rd(7'h71));
      q1.push_back(rd(7'h72));
      drain();

      q0.push_back(wr(7'h7F, 32'hDEADBEEF, 4'hF));
      step();
      q1.push_back(rd(7'h7F));
      drain();

      // reset one cycle after a read accept drops the response
      q0.push_back(rd(7'h10));
      step();
      q1.push_back(rd(7'h70));
      RST_N = 1'b0;
      step();
      step();
      RST_N = 1'b1;
      drain();

      for (int i = 0; i < 400; i++) begin
         if (q0.size() < 2 && $urandom_range(0, 2) != 0) q0.push_back(rand_op());
         if (q1.size() < 2 && $urandom_range(0, 2) != 0) q1.push_back(rand_op());
         if (i == 200) RST_N = 1'b0;
         if (i == 202) RST_N = 1'b1;
         step();
      end
      RST_N = 1'b1;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
